// File: rtl/network_step_controller.sv
// network_step_controller
//
// Time-step sequencer and output-stream merger for a T-block spiking network.
// A run of num_steps time steps is executed as follows:
//   1. A single-cycle time_step pulse is sent to every block, together with any
//      queued force-spike requests.
//   2. The controller waits until every block has reported done and all output
//      packets have drained.
//   3. It then advances to the next step.
// Independently, the T block output streams are merged into one stream by a
// round-robin arbiter that locks onto a block for a whole packet.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start, num_steps                run request (IDLE only) and step count
//   force_spike_en/_block_select/
//   force_spike_neuron_select       force-spike request and its target
//   block_time_step                 per-block step pulse
//   block_force_spike_en            per-block force strobe (with the step pulse)
//   block_force_neuron              per-block forced neuron index, NA bits each
//   block_done                      per-block step-complete indication
//   s_tvalid/s_tdata/s_tlast/
//   s_tready                        T block streams (block j data at [j*W +: W])
//   m_tvalid/m_tdata/m_tlast/
//   m_tuser/m_tready                merged stream, m_tuser = source block
//   busy, step_count, done          run status
module network_step_controller #(
    parameter int T  = 4,
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int SW = 16,
    parameter int TA = (T > 1) ? $clog2(T) : 1,
    parameter int NA = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [SW-1:0]   num_steps,
    input  logic            force_spike_en,
    input  logic [TA-1:0]   force_spike_block_select,
    input  logic [NA-1:0]   force_spike_neuron_select,
    output logic [T-1:0]    block_time_step,
    output logic [T-1:0]    block_force_spike_en,
    output logic [T*NA-1:0] block_force_neuron,
    input  logic [T-1:0]    block_done,
    input  logic [T-1:0]    s_tvalid,
    input  logic [T*W-1:0]  s_tdata,
    input  logic [T-1:0]    s_tlast,
    output logic [T-1:0]    s_tready,
    output logic            m_tvalid,
    output logic [W-1:0]    m_tdata,
    output logic            m_tlast,
    output logic [TA-1:0]   m_tuser,
    input  logic            m_tready,
    output logic            busy,
    output logic [SW-1:0]   step_count,
    output logic            done
);

    typedef enum logic [1:0] {IDLE, STEP, WAIT, FINISH} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   num_steps_q, num_steps_d;
    logic [SW-1:0]   step_count_q, step_count_d;
    logic [SW-1:0]   step_count_inc;
    logic [T-1:0]    done_seen_q, done_seen_d;
    logic [T-1:0]    pending_q, pending_d;
    logic [NA-1:0]   pend_idx_q [T];
    logic [NA-1:0]   pend_idx_d [T];
    logic            locked_q, locked_d;
    logic [TA-1:0]   grant_q, grant_d;
    logic [TA-1:0]   rr_ptr_q, rr_ptr_d;
    logic            step_complete;

    assign step_count_inc = step_count_q + SW'(1);

    // A step is only over once every block has finished and nothing is left in
    // flight: no packet half-way through the merger and no block offering data.
    assign step_complete = (&done_seen_q) && !locked_q && (s_tvalid == '0);

    // Sequencer next-state logic. done_seen is cleared in STEP, so a block_done
    // arriving in that same cycle is deliberately dropped.
    always_comb begin
        state_d      = state_q;
        num_steps_d  = num_steps_q;
        step_count_d = step_count_q;
        done_seen_d  = done_seen_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_steps_d  = num_steps;
                    step_count_d = '0;
                    state_d      = (num_steps == '0) ? FINISH : STEP;
                end
            end
            STEP: begin
                done_seen_d = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                done_seen_d = done_seen_q | block_done;
                if (step_complete) begin
                    step_count_d = step_count_inc;
                    state_d      = (step_count_inc == num_steps_q) ? FINISH : STEP;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Force-spike queue. Entries are consumed in STEP. The capture runs after
    // the clear, so a request made during STEP survives to the following step.
    // A newer request to the same block overwrites the older one. A select
    // that is >= T matches no block and is dropped.
    always_comb begin
        pending_d  = pending_q;
        pend_idx_d = pend_idx_q;
        if (state_q == STEP) begin
            pending_d = '0;
        end
        if (force_spike_en) begin
            for (int j = 0; j < T; j++) begin
                if (force_spike_block_select == j[TA-1:0]) begin
                    pending_d[j]  = 1'b1;
                    pend_idx_d[j] = force_spike_neuron_select;
                end
            end
        end
    end

    // Per-block step outputs are decoded straight from registered state.
    always_comb begin
        block_force_spike_en = '0;
        block_force_neuron   = '0;
        if (state_q == STEP) begin
            block_force_spike_en = pending_q;
            for (int j = 0; j < T; j++) begin
                if (pending_q[j]) begin
                    block_force_neuron[j*NA +: NA] = pend_idx_q[j];
                end
            end
        end
    end

    assign block_time_step = (state_q == STEP) ? {T{1'b1}} : {T{1'b0}};
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FINISH);
    assign step_count      = step_count_q;

    // Packet-locked round-robin merger. While unlocked, the winner is chosen
    // and locked for the next cycle. This costs one bubble per packet, but it
    // keeps the grant decision off the combinational ready/valid path. While
    // locked, the granted stream is wired straight through to the output.
    always_comb begin
        logic found;
        int   idx;
        locked_d = locked_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        m_tuser  = '0;
        s_tready = '0;
        found    = 1'b0;
        idx      = 0;
        if (locked_q) begin
            for (int j = 0; j < T; j++) begin
                if (grant_q == j[TA-1:0]) begin
                    m_tvalid    = s_tvalid[j];
                    m_tdata     = s_tdata[j*W +: W];
                    m_tlast     = s_tlast[j];
                    s_tready[j] = m_tready;
                end
            end
            m_tuser = grant_q;
            if (m_tvalid && m_tready && m_tlast) begin
                locked_d = 1'b0;
                rr_ptr_d = (grant_q == TA'(T - 1)) ? '0 : grant_q + 1'b1;
            end
        end else begin
            for (int k = 0; k < T; k++) begin
                idx = (int'(rr_ptr_q) + k) % T;
                for (int j = 0; j < T; j++) begin
                    if (!found && (j == idx) && s_tvalid[j]) begin
                        found   = 1'b1;
                        grant_d = j[TA-1:0];
                    end
                end
            end
            if (found) begin
                locked_d = 1'b1;
            end
        end
    end

    // State register for the sequencer, the force queue and the arbiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            num_steps_q  <= '0;
            step_count_q <= '0;
            done_seen_q  <= '0;
            pending_q    <= '0;
            pend_idx_q   <= '{default: '0};
            locked_q     <= 1'b0;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            num_steps_q  <= num_steps_d;
            step_count_q <= step_count_d;
            done_seen_q  <= done_seen_d;
            pending_q    <= pending_d;
            pend_idx_q   <= pend_idx_d;
            locked_q     <= locked_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: doc/network_step_controller.md
Name: network_step_controller

Overview:
- Time-step sequencer and output-stream merger for a T-block spiking network.
- Runs a programmed number of time steps: issues per-block time_step pulses, routes force-spike requests to the addressed block, waits for every block's done and for its output packets to drain, then advances.
- Merges the T per-block output streams into one stream with round-robin, packet-locked arbitration; m_tuser tags each beat with its source block.

Parameters:
- T, 4, number of neuron blocks (>=1).
- N, 16, neurons per block.
- W, 16, data width of each block stream.
- SW, 16, width of step counter and num_steps.
- TA, max(1,$clog2(T)), block-index width (derived).
- NA, max(1,$clog2(N)), neuron-index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  run request, sampled in IDLE only.
- num_steps  in  SW  steps to run, latched on accepted start.
- force_spike_en  in  1  force-spike request strobe.
- force_spike_block_select  in  TA  target block.
- force_spike_neuron_select  in  NA  target neuron.
- block_time_step  out  T  per-block step pulse.
- block_force_spike_en  out  T  per-block force strobe, coincident with block_time_step.
- block_force_neuron  out  T*NA  per-block forced neuron index.
- block_done  in  T  per-block step-complete pulse/level.
- s_tvalid  in  T  block stream valid.
- s_tdata  in  T*W  block stream data, block j at [j*W +: W].
- s_tlast  in  T  block packet end.
- s_tready  out  T  block stream ready.
- m_tvalid  out  1  merged valid.
- m_tdata  out  W  merged data.
- m_tlast  out  1  merged last.
- m_tuser  out  TA  source block of current beat.
- m_tready  in  1  downstream ready.
- busy  out  1  high in any state but IDLE.
- step_count  out  SW  completed steps in current run.
- done  out  1  one-cycle pulse at run completion.

Behaviour:
- Clock is clk; reset is synchronous, active-high. Reset clears all state. All outputs are 0 after reset: FSM in IDLE, pending force cleared, lock cleared, round-robin pointer at 0.
- FSM states: IDLE, STEP, WAIT, FINISH.
- IDLE: start=1 latches num_steps and clears step_count.
  - num_steps==0 goes directly to FINISH; no pulses are issued.
  - Otherwise go to STEP.
- STEP (one cycle):
  - block_time_step = all ones.
  - For each block with a pending force: block_force_spike_en[j]=1 and block_force_neuron[j]=pending index; that pending entry clears.
  - done_seen[T] clears. Next state is WAIT.
- WAIT:
  - done_seen[j] sets on block_done[j]=1.
  - Step completes when &done_seen==1, no packet is locked, and s_tvalid==0.
  - On completion, step_count increments. If step_count+1==num_steps go to FINISH, else go to STEP on the next cycle.
- FINISH (one cycle): done=1, then IDLE. step_count holds its value until the next accepted start.
- Force capture:
  - Any cycle except STEP: force_spike_en sets pending[sel] and stores the neuron index. A later request to the same block overwrites the earlier one (last wins).
  - Request in a STEP cycle: held and applied at the next STEP.
  - Block select >= T: ignored.
  - Pending entries persist across IDLE.
- Arbiter (active in all states):
  - When unlocked and |s_tvalid: grant the first requester at or after rr_ptr (wrapping) and lock on the next cycle. This costs one bubble cycle per packet.
  - When locked to g: m_tvalid=s_tvalid[g], m_tdata/m_tlast from g, m_tuser=g, s_tready[g]=m_tready; all other s_tready are 0. These paths are combinational (zero latency).
  - A beat with s_tlast accepted (valid&ready) unlocks and sets rr_ptr=g+1 mod T.
  - When unlocked: m_tvalid=0 and s_tready=0.
- Simultaneous events:
  - block_done in the same cycle as STEP is ignored; done_seen clearing wins.
  - start outside IDLE is ignored.
- T==1: arbiter degenerates to a pass-through with the 1-cycle lock bubble; m_tuser=0.

Test Plan:
- T=4, num_steps=3, blocks pulse done 5 cycles after each step, no streams -> exactly 3 block_time_step=4'hF pulses, done pulse once, step_count=3, busy low after FINISH.
- num_steps=0, start -> no time_step pulses; done high 1 cycle later; step_count=0.
- force_spike_en with block=2, neuron=7 in IDLE, then start num_steps=2 -> first STEP has block_force_spike_en=4'b0100 and block_force_neuron[2]=7; second STEP has no force.
- Blocks 1 and 3 each send 3-beat packets (tlast on beat 3), rr_ptr=0, m_tready=1 -> block 1's packet then block 3's, m_tuser 1,1,1,3,3,3, one bubble cycle between packets, no interleaving.
- Done from all blocks while block 0's packet is mid-stream with m_tready toggling 1,0,1 -> step does not complete until block 0's tlast beat is accepted; next STEP follows one cycle later.
- reset asserted in WAIT with a packet locked -> next cycle all outputs 0, FSM IDLE, pending force cleared; new start runs normally.
